// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling stage.
// Window geometry and the unsigned compare helper.
package pool_pkg;

  localparam int POOL_K      = 2;
  localparam int POOL_STRIDE = 2;

  // Widest pixel the compare helper accepts.
  localparam int ACT_W_MAX = 32;

  function automatic logic [ACT_W_MAX-1:0] max2(
    input logic [ACT_W_MAX-1:0] a,
    input logic [ACT_W_MAX-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: holds horizontal maxima of the even row.
// Synchronous write, combinational read, no reset.
module pool_line_buf #(
  parameter int W     = 9,
  parameter int DEPTH = 7,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pool over a raster-order pixel stream.
// One pooled pixel per closed window, one cycle after the closing pixel.
module max_pool_2x2
  import pool_pkg::*;
#(
  parameter int ACT_BIT = 9,
  parameter int MAP_W   = 14,
  parameter int MAP_H   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ACT_BIT-1:0] in_act,
  output logic               out_valid,
  output logic [ACT_BIT-1:0] out_act,
  output logic               out_last
);

  localparam int CW    = $clog2(MAP_W);
  localparam int RW    = $clog2(MAP_H);
  localparam int LB_D  = MAP_W / POOL_STRIDE;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  if (MAP_W < POOL_K || (MAP_W % 2) != 0 ||
      MAP_H < POOL_K || (MAP_H % 2) != 0 ||
      ACT_BIT > ACT_W_MAX || ACT_BIT < 1) begin : g_geom_chk
    $fatal(1, "max_pool_2x2: bad MAP_W/MAP_H/ACT_BIT");
  end

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [ACT_BIT-1:0] pair_q, pair_d;
  logic               out_valid_q, out_valid_d;
  logic [ACT_BIT-1:0] out_act_q, out_act_d;
  logic               out_last_q, out_last_d;

  logic               lb_we;
  logic [LB_AW-1:0]   lb_addr;
  logic [ACT_BIT-1:0] lb_rdata;
  logic [ACT_BIT-1:0] hmax;
  logic [ACT_BIT-1:0] wmax;
  logic               col_last;
  logic               row_last;
  logic               col_odd;
  logic               row_odd;

  assign col_last = (col_q == CW'(MAP_W - 1));
  assign row_last = (row_q == RW'(MAP_H - 1));
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign lb_addr  = LB_AW'(col_q >> 1);

  assign hmax = ACT_BIT'(max2(ACT_W_MAX'(pair_q),
                              ACT_W_MAX'(in_act)));
  assign wmax = ACT_BIT'(max2(ACT_W_MAX'(hmax),
                              ACT_W_MAX'(lb_rdata)));

  pool_line_buf #(
    .W     (ACT_BIT),
    .DEPTH (LB_D),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_valid_d = 1'b0;
    out_act_d   = out_act_q;
    out_last_d  = 1'b0;
    lb_we       = 1'b0;

    if (in_valid) begin
      if (!col_odd) begin
        pair_d = in_act;
      end else if (!row_odd) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_act_d   = wmax;
        out_last_d  = col_last && row_last;
      end

      // Raster advance; the corner wraps both into a new frame.
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_act   = out_act_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of the activation stage in the VGG-16 datapath. It consumes one activated pixel per `in_valid` cycle in raster order and emits one pooled pixel per completed 2×2 window. A half-width line buffer holds the horizontal maxima of each even row, so no full-frame storage is needed. Pooled pixels feed the IFM input of the next convolution layer.

## Interface
- `ACT_BIT`, 9: pixel width; matches the activation stage output width (IFM_BIT+1).
- `MAP_W`, 14: feature-map width in pixels; must be even and ≥2.
- `MAP_H`, 14: feature-map height in pixels; must be even and ≥2.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: `in_act` carries the next raster-order pixel this cycle.
- `in_act` input ACT_BIT: activated pixel, unsigned (post-ReLU).
- `out_valid` output 1: `out_act` carries a pooled pixel this cycle.
- `out_act` output ACT_BIT: pooled pixel, unsigned.
- `out_last` output 1: high together with `out_valid` on the final pooled pixel of a frame.

## Operation
- Position counters `col` (0..MAP_W-1) and `row` (0..MAP_H-1) advance only on `in_valid`. `col` wraps to 0 and increments `row`; at (MAP_H-1, MAP_W-1) both wrap to 0, and the next pixel starts a new frame.
- Pair register: on an even `col`, latch `in_act`.
- Even row, odd `col`: write max(pair, `in_act`) to line buffer entry `col>>1`. No output.
- Odd row, odd `col`: compute max(pair, `in_act`, linebuf[`col>>1`]) and register it into `out_act`; assert `out_valid` for exactly one cycle.
- `out_last` is asserted when the window closes at (MAP_H-1, MAP_W-1).
- All comparisons are unsigned at full ACT_BIT width. No truncation or saturation is applied; the output is always exactly one of the input values.
- Outputs per frame: (MAP_W/2)·(MAP_H/2).
- Upstream has no backpressure. The downstream stage must accept `out_valid` unconditionally.
- Equal values: any of the equal candidates may be selected. They are bit-identical, so the output is unaffected.

## Timing
- Reset values: `out_valid`=0, `out_act`=0, `out_last`=0, `col`=0, `row`=0, pair register=0. Line buffer contents are not reset, because every entry is written in an even row before it is read in the following odd row.
- Latency: `out_valid` rises on the clock edge after the `in_valid` cycle that carries the bottom-right pixel of a window. That is one cycle of latency.
- `out_valid` and `out_last` are pulses. They drop in the following cycle unless another window closes in that cycle.
- `out_act` holds its last value while `out_valid` is 0.
- `in_valid` may be deasserted for any number of cycles at any position. Counters, pair register and line buffer hold during the gap, and the result is identical to gap-free streaming.
- Back-to-back frames with no gap are supported. Pixel (0,0) of frame N+1 may arrive in the cycle right after the last pixel of frame N, while `out_valid`/`out_last` for frame N are high.
- Reset mid-frame: all state returns to reset values immediately (asynchronously). The partial frame is discarded, with no output for it. The next `in_valid` pixel is treated as (0,0).
- In any cycle with `in_valid`=0, the line buffer is not written.

## Structure
- Shared package `pool_pkg`: localparams `POOL_K`=2 and `POOL_STRIDE`=2, plus a `max2` function for unsigned ACT_BIT compare. Counter widths are derived with $clog2(MAP_W) and $clog2(MAP_H).
- Sub-module `pool_line_buf`:
  - MAP_W/2 entries × ACT_BIT.
  - One synchronous write port and one combinational read port.
  - Register array, no reset.
- Elaboration-time check: raise a fatal error if MAP_W or MAP_H is odd or below 2.

## Test plan
All scenarios use MAP_W=4, MAP_H=4 and ACT_BIT=9 unless stated.
- **Ramp:** pixels 0..15 back-to-back → `out_act` 5, 7, 13, 15 on four single-cycle `out_valid` pulses. `out_last` is high only with 15. Each pulse comes one cycle after pixels 5, 7, 13 and 15.
- **Max in each corner:** the 9-bit max 511 placed at top-left, top-right, bottom-left and bottom-right of successive windows, zeros elsewhere → four outputs of 511. Also the full-range unsigned case: window {256, 255, 1, 0} → 256.
- **Gaps:** the ramp frame with a random 0–5 idle cycles between pixels → same outputs 5, 7, 13, 15. Each pulse is exactly one cycle after the closing pixel.
- **Back-to-back frames:** the ramp followed immediately by the reversed ramp 15..0 → 5, 7, 13, 15, then 15, 13, 7, 5. `out_last` is high with the fourth and eighth outputs.
- **Reset mid-frame:** assert `rst` for 1 cycle after 9 pixels of a ramp, then send a full ramp → no output from the aborted frame. Exactly 5, 7, 13, 15 follow. All outputs read 0 during and immediately after reset.
- **Default geometry:** with MAP_W=MAP_H=14, random values 0–511 → 49 outputs that match a reference 2×2 max model. `out_last` appears only on the 49th output.
